// File: rtl/pipelined_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_decoder
// Purpose  : Registered, handshaked instruction decoder with two-word
//            long-immediate assembly and call/return address storage.
//            Define DECODER_CALL_STACK_EN for a STACK_DEPTH-entry circular
//            return stack; otherwise a single link register is used.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_decoder #(
    parameter int W           = 16,
    parameter int AW          = 16,
    parameter int RA          = 5,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  INS,
    input  logic [AW-1:0] INS_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          A_ce,
    output logic          REGS_ce,
    output logic          load_pc,
    output logic [AW-1:0] new_pc,
    output logic [AW-1:0] new_linkreg,
    output logic [RA-1:0] REGS_addr,
    output logic [3:0]    opcode,
    output logic [W-1:0]  instant,
    output logic          PC_source,
    output logic          arg_source,
    output logic          stack_overflow,
    output logic          stack_underflow
);

    localparam int SIW = W - 5 - RA;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXT  = 1'b1;

    localparam logic [3:0] OP_LAST_ALU = 4'hB;
    localparam logic [3:0] OP_STORE    = 4'hC;
    localparam logic [3:0] OP_JMP      = 4'hD;
    localparam logic [3:0] OP_CALL     = 4'hE;
    localparam logic [3:0] OP_RET      = 4'hF;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;

    logic          w_accept;
    logic          w_long0;
    logic          w_latch0;
    logic          w_load;
    logic          w_in_ext;

    logic [3:0]    r_op;
    logic [RA-1:0] r_ra;
    logic [AW-1:0] r_addr;

    logic [3:0]    w_op;
    logic          w_i;
    logic [RA-1:0] w_ra;
    logic [AW-1:0] w_addr;
    logic [W-1:0]  w_instant;

    logic          w_d_a_ce;
    logic          w_d_regs_ce;
    logic          w_d_load_pc;
    logic          w_d_pc_source;
    logic [AW-1:0] w_d_new_pc;
    logic [AW-1:0] w_d_linkreg;

    logic          w_push;
    logic [AW-1:0] w_pop_val;

    // Reset is folded in so the handshake reads 0 while rst_n is low.
    assign in_ready = rst_n && !flush && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_long0  = INS[W-5] && (&INS[SIW-1:0]);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept && w_long0) w_state_nxt = EXT;
                EXT:     if (w_accept)            w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        w_latch0 = 1'b0;
        w_load   = 1'b0;
        w_in_ext = 1'b0;
        case (r_state)
            IDLE: begin
                w_latch0 = w_accept && w_long0;
                w_load   = w_accept && !w_long0;
            end
            EXT: begin
                w_in_ext = 1'b1;
                w_load   = w_accept;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Word-0 holding register for long-form instructions
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_ra   <= '0;
            r_addr <= '0;
        end else if (w_latch0) begin
            r_op   <= INS[W-1:W-4];
            r_ra   <= INS[W-6:W-5-RA];
            r_addr <= INS_addr;
        end
    end

    // A long form always carries I=1, so no need to store it.
    assign w_op      = w_in_ext ? r_op   : INS[W-1:W-4];
    assign w_i       = w_in_ext ? 1'b1   : INS[W-5];
    assign w_ra      = w_in_ext ? r_ra   : INS[W-6:W-5-RA];
    assign w_addr    = w_in_ext ? r_addr : INS_addr;
    assign w_instant = w_in_ext ? INS    : W'(INS[SIW-1:0]);

    // ------------------------------------------------------------------
    // Opcode class decode
    // ------------------------------------------------------------------
    always_comb begin
        w_d_a_ce      = (w_op <= OP_LAST_ALU);
        w_d_regs_ce   = (w_op == OP_STORE);
        w_d_load_pc   = 1'b0;
        w_d_pc_source = 1'b0;
        w_d_new_pc    = '0;
        w_d_linkreg   = '0;
        case (w_op)
            OP_JMP: begin
                w_d_load_pc = 1'b1;
                w_d_new_pc  = AW'(w_instant);
            end
            OP_CALL: begin
                w_d_load_pc = 1'b1;
                w_d_new_pc  = AW'(w_instant);
                w_d_linkreg = w_addr + (w_in_ext ? AW'(2) : AW'(1));
            end
            OP_RET: begin
                w_d_load_pc   = 1'b1;
                w_d_pc_source = 1'b1;
                w_d_new_pc    = w_pop_val;
            end
            default: ;
        endcase
    end

    assign w_push = w_load && (w_op == OP_CALL);

    // ------------------------------------------------------------------
    // Return address storage
    // ------------------------------------------------------------------
`ifdef DECODER_CALL_STACK_EN
    localparam int PW = $clog2(STACK_DEPTH);

    logic [AW-1:0] r_stack [STACK_DEPTH];
    logic [PW-1:0] r_sp;
    logic [PW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;

    assign w_full    = (r_count == (PW+1)'(STACK_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = w_load && (w_op == OP_RET);
    assign w_pop_val = w_empty ? '0 : r_stack[r_sp - PW'(1)];

    // When full, r_sp already points at the oldest slot, so a push
    // overwrites it naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STACK_DEPTH; k++) begin
                r_stack[k] <= '0;
            end
            r_sp            <= '0;
            r_count         <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (w_push) begin
            r_stack[r_sp] <= w_d_linkreg;
            r_sp          <= r_sp + PW'(1);
            if (w_full) begin
                stack_overflow <= 1'b1;
            end else begin
                r_count <= r_count + (PW+1)'(1);
            end
        end else if (w_pop) begin
            if (w_empty) begin
                stack_underflow <= 1'b1;
            end else begin
                r_sp    <= r_sp - PW'(1);
                r_count <= r_count - (PW+1)'(1);
            end
        end
    end
`else
    logic [AW-1:0] r_link;

    assign w_pop_val       = r_link;
    assign stack_overflow  = 1'b0;
    assign stack_underflow = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_link <= '0;
        end else if (w_push) begin
            r_link <= w_d_linkreg;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            A_ce        <= 1'b0;
            REGS_ce     <= 1'b0;
            load_pc     <= 1'b0;
            new_pc      <= '0;
            new_linkreg <= '0;
            REGS_addr   <= '0;
            opcode      <= '0;
            instant     <= '0;
            PC_source   <= 1'b0;
            arg_source  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_load) begin
            out_valid   <= 1'b1;
            A_ce        <= w_d_a_ce;
            REGS_ce     <= w_d_regs_ce;
            load_pc     <= w_d_load_pc;
            new_pc      <= w_d_new_pc;
            new_linkreg <= w_d_linkreg;
            REGS_addr   <= w_ra;
            opcode      <= w_op;
            instant     <= w_instant;
            PC_source   <= w_d_pc_source;
            arg_source  <= w_i;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_decoder
// Purpose  : Self-checking bench: directed cases plus randomized traffic
//            compared every cycle against a behavioural decoder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_decoder;

    localparam int W  = 16;
    localparam int AW = 16;
    localparam int RA = 5;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  INS = '0;
    logic [AW-1:0] INS_addr = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          A_ce, REGS_ce, load_pc, PC_source, arg_source;
    logic [AW-1:0] new_pc, new_linkreg;
    logic [RA-1:0] REGS_addr;
    logic [3:0]    opcode;
    logic [W-1:0]  instant;
    logic          stack_overflow, stack_underflow;

    always #5 clk = ~clk;

    pipelined_decoder #(.W(W), .AW(AW), .RA(RA), .STACK_DEPTH(SD)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .INS(INS), .INS_addr(INS_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .A_ce(A_ce), .REGS_ce(REGS_ce), .load_pc(load_pc),
        .new_pc(new_pc), .new_linkreg(new_linkreg),
        .REGS_addr(REGS_addr), .opcode(opcode), .instant(instant),
        .PC_source(PC_source), .arg_source(arg_source),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid = 0, m_a_ce = 0, m_regs_ce = 0, m_load_pc = 0;
    logic        m_pc_src = 0, m_arg = 0, m_ovf = 0, m_unf = 0, m_ext = 0;
    logic [15:0] m_new_pc = 0, m_link = 0, m_inst = 0, m_w0 = 0, m_a0 = 0;
    logic [4:0]  m_ra = 0;
    logic [3:0]  m_op = 0;
    logic [15:0] m_stack[$];
    logic [15:0] m_single = 0;
    logic        m_acc;

    function automatic logic is_long(input logic [15:0] w);
        return (((w >> 11) & 16'd1) == 16'd1) && ((w & 16'h3F) == 16'h3F);
    endfunction

    task automatic m_push(input logic [15:0] v);
`ifdef DECODER_CALL_STACK_EN
        m_stack.push_back(v);
        if (m_stack.size() > SD) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
        end
`else
        m_single = v;
`endif
    endtask

    task automatic m_pop(output logic [15:0] v);
`ifdef DECODER_CALL_STACK_EN
        if (m_stack.size() == 0) begin
            v = 16'h0;
            m_unf = 1'b1;
        end else begin
            v = m_stack.pop_back();
        end
`else
        v = m_single;
`endif
    endtask

    task automatic m_emit(input logic [15:0] w0, input logic [15:0] a0,
                          input logic [15:0] imm, input logic lng);
        int op;
        op = int'(w0 >> 12);
        m_valid   = 1'b1;
        m_op      = 4'(op);
        m_ra      = 5'((w0 >> 6) & 16'h1F);
        m_inst    = imm;
        m_arg     = ((w0 >> 11) & 16'd1) == 16'd1;
        m_a_ce    = op < 12;
        m_regs_ce = op == 12;
        m_load_pc = op >= 13;
        m_pc_src  = op == 15;
        m_new_pc  = 16'h0;
        m_link    = 16'h0;
        if (op == 13) m_new_pc = imm;
        if (op == 14) begin
            m_new_pc = imm;
            m_link   = a0 + (lng ? 16'd2 : 16'd1);
            m_push(m_link);
        end
        if (op == 15) m_pop(m_new_pc);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_a_ce = 0; m_regs_ce = 0; m_load_pc = 0; m_pc_src = 0;
            m_arg = 0; m_ovf = 0; m_unf = 0; m_ext = 0; m_new_pc = 0; m_link = 0;
            m_inst = 0; m_ra = 0; m_op = 0; m_single = 0;
            m_stack.delete();
        end else begin
            m_acc = in_valid && !flush && (!m_valid || out_ready);
            if (flush) begin
                m_valid = 1'b0;
                m_ext   = 1'b0;
            end else if (m_acc && !m_ext && is_long(INS)) begin
                m_ext   = 1'b1;
                m_w0    = INS;
                m_a0    = INS_addr;
                m_valid = 1'b0;
            end else if (m_acc) begin
                if (m_ext) m_emit(m_w0, m_a0, INS, 1'b1);
                else       m_emit(INS, INS_addr, INS & 16'h3F, 1'b0);
                m_ext = 1'b0;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("out_valid", out_valid, m_valid);
        chk("in_ready", in_ready, rst_n && !flush && (!m_valid || out_ready));
        chk("stack_overflow", stack_overflow, m_ovf);
        chk("stack_underflow", stack_underflow, m_unf);
        if (m_valid) begin
            chk("opcode", opcode, m_op);
            chk("REGS_addr", REGS_addr, m_ra);
            chk("instant", instant, m_inst);
            chk("arg_source", arg_source, m_arg);
            chk("A_ce", A_ce, m_a_ce);
            chk("REGS_ce", REGS_ce, m_regs_ce);
            chk("load_pc", load_pc, m_load_pc);
            chk("PC_source", PC_source, m_pc_src);
            chk("new_pc", new_pc, m_new_pc);
            chk("new_linkreg", new_linkreg, m_link);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] addr,
                         input logic ordy, input logic fl);
        in_valid  = v;
        INS       = ins;
        INS_addr  = addr;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_A_ce"}, A_ce, 0);
        chk({tag, "_REGS_ce"}, REGS_ce, 0);
        chk({tag, "_load_pc"}, load_pc, 0);
        chk({tag, "_new_pc"}, new_pc, 0);
        chk({tag, "_new_linkreg"}, new_linkreg, 0);
        chk({tag, "_REGS_addr"}, REGS_addr, 0);
        chk({tag, "_opcode"}, opcode, 0);
        chk({tag, "_instant"}, instant, 0);
        chk({tag, "_PC_source"}, PC_source, 0);
        chk({tag, "_arg_source"}, arg_source, 0);
        chk({tag, "_overflow"}, stack_overflow, 0);
        chk({tag, "_underflow"}, stack_underflow, 0);
    endtask

    logic [15:0] exp_ret [5];
    logic        exp_ovf, exp_unf;
    logic [15:0] rnd_ins;

    initial begin
`ifdef DECODER_CALL_STACK_EN
        exp_ret = '{16'h0105, 16'h0104, 16'h0103, 16'h0102, 16'h0000};
        exp_ovf = 1'b1;
        exp_unf = 1'b1;
`else
        exp_ret = '{16'h0105, 16'h0105, 16'h0105, 16'h0105, 16'h0105};
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`endif
        // Reset: in_ready must stay low even with out_ready high
        drive(1, 16'h3A85, 16'h0010, 1, 0);
        repeat (3) cyc();
        chk_all_zero("reset");
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0);
        cyc();

        // Single-word ALU with immediate
        drive(1, 16'h3A85, 16'h0010, 1, 0);
        cyc();
        drive(0, 0, 0, 1, 0);
        chk("alu_out_valid", out_valid, 1);
        chk("alu_opcode", opcode, 4'h3);
        chk("alu_A_ce", A_ce, 1);
        chk("alu_arg_source", arg_source, 1);
        chk("alu_REGS_addr", REGS_addr, 5'h0A);
        chk("alu_instant", instant, 16'h0005);
        cyc();

        // Long-form CALL: no output after word 0
        drive(1, 16'hE83F, 16'h0020, 1, 0);
        cyc();
        drive(0, 0, 0, 1, 0);
        chk("long_w0_no_out", out_valid, 0);
        cyc();
        drive(1, 16'h1234, 16'h0021, 1, 0);
        cyc();
        drive(0, 0, 0, 1, 0);
        chk("long_out_valid", out_valid, 1);
        chk("long_opcode", opcode, 4'hE);
        chk("long_new_pc", new_pc, 16'h1234);
        chk("long_linkreg", new_linkreg, 16'h0022);
        chk("long_load_pc", load_pc, 1);
        chk("long_instant", instant, 16'h1234);
        cyc();
        chk("long_single_out", out_valid, 0);

        // Backpressure
        drive(1, 16'hC145, 16'h0030, 1, 0);
        cyc();
        drive(1, 16'h5000, 16'h0031, 0, 0);
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_REGS_ce", REGS_ce, 1);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_opcode", opcode, 4'hC);
            chk("bp_hold_instant", instant, 16'h0005);
        end
        drive(1, 16'h5000, 16'h0031, 1, 0);
        cyc();
        drive(0, 0, 0, 1, 0);
        chk("bp_reload_valid", out_valid, 1);
        chk("bp_reload_opcode", opcode, 4'h5);
        cyc();

        // Five CALLs then five RETs
        for (int k = 0; k < 5; k++) begin
            drive(1, 16'hE001, 16'h0100 + 16'(k), 1, 0);
            cyc();
            chk("call_linkreg", new_linkreg, 16'h0101 + 16'(k));
        end
        chk("call_overflow", stack_overflow, exp_ovf);
        for (int k = 0; k < 5; k++) begin
            drive(1, 16'hF000, 16'h0200 + 16'(k), 1, 0);
            cyc();
            chk("ret_new_pc", new_pc, exp_ret[k]);
            chk("ret_PC_source", PC_source, 1);
        end
        chk("ret_underflow", stack_underflow, exp_unf);
        drive(0, 0, 0, 1, 0);
        cyc();

        // Flush while waiting for word 1 (same-cycle beat is ignored)
        drive(1, 16'hE83F, 16'h0040, 1, 0);
        cyc();
        drive(1, 16'h1111, 16'h0041, 1, 1);
        #1;
        chk("flush_in_ready", in_ready, 0);
        cyc();
        drive(1, 16'hD005, 16'h0042, 1, 0);
        cyc();
        drive(0, 0, 0, 1, 0);
        chk("flush_jmp_valid", out_valid, 1);
        chk("flush_jmp_opcode", opcode, 4'hD);
        chk("flush_jmp_new_pc", new_pc, 16'h0005);
        chk("flush_jmp_load_pc", load_pc, 1);
        chk("flush_jmp_linkreg", new_linkreg, 16'h0000);
        cyc();
        chk("flush_no_extra", out_valid, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rnd_ins = 16'($urandom);
            if ($urandom_range(0, 9) < 2) rnd_ins = rnd_ins | 16'h083F;
            drive($urandom_range(0, 3) != 0, rnd_ins, 16'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            cyc();
        end
        drive(0, 0, 0, 1, 1);
        cyc();
        drive(0, 0, 0, 1, 0);
        cyc();

        // Asynchronous reset while the output register is full
        drive(1, 16'h3A85, 16'h0050, 1, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        chk("arst_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        cyc();
        cyc();
        rst_n = 1'b1;
        drive(1, 16'hD007, 16'h0060, 1, 0);
        cyc();
        drive(0, 0, 0, 1, 0);
        chk("post_rst_new_pc", new_pc, 16'h0007);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
